segway_math_pipe: RTL



---
 rtl/segway_pkg.sv | 20 ++
 rtl/wheel_shaper.sv | 103 ++++++++++
 rtl/segway_math_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/segway_pkg.sv
// Shared defaults and data types for the Segway wheel-speed math pipeline.
package segway_pkg;

    localparam int SEG_W          = 12;
    localparam int SEG_SS_W       = 8;
    localparam int SEG_SS_STEP    = 1;
    localparam int SEG_MIN_DUTY   = 168;
    localparam int SEG_LOW_BAND   = 42;
    localparam int SEG_GAIN_SHIFT = 2;
    localparam int SEG_STEER_LO   = 'h200;
    localparam int SEG_STEER_HI   = 'hE00;
    localparam int SEG_OVERSPEED  = 1536;
    localparam int SEG_FAST_CNT   = 4;
    localparam int SEG_SLEW       = 64;

    // Wheel speed and the one-bit-wider torque sum it is derived from.
    typedef logic signed [SEG_W-1:0] speed_t;
    typedef logic signed [SEG_W:0]   torque_t;

endpackage

// File: rtl/wheel_shaper.sv
// One wheel: deadzone shaping, saturation, overspeed flag (stage 2) and the
// slew-limited speed register (stage 3).
module wheel_shaper
    import segway_pkg::*;
#(
    parameter int W          = SEG_W,
    parameter int MIN_DUTY   = SEG_MIN_DUTY,
    parameter int LOW_BAND   = SEG_LOW_BAND,
    parameter int GAIN_SHIFT = SEG_GAIN_SHIFT,
    parameter int OVERSPEED  = SEG_OVERSPEED,
    parameter int SLEW       = SEG_SLEW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_p1,
    input  logic         pwr_p1,
    input  logic [W:0]   torque,
    input  logic         vld_p2,
    input  logic         pwr_p2,
    output logic [W-1:0] spd,
    output logic         over_p2
);

    // Two guard bits cover the deadzone offset on a full-scale torque.
    localparam int SH_W = W + 3;

    localparam logic signed [SH_W-1:0] LB      = SH_W'(LOW_BAND);
    localparam logic signed [SH_W-1:0] NEG_LB  = -LB;
    localparam logic signed [SH_W-1:0] MD      = SH_W'(MIN_DUTY);
    localparam logic signed [SH_W-1:0] OV      = SH_W'(OVERSPEED);
    localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'((2 ** (W - 1)) - 1);
    localparam logic signed [SH_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [W-1:0]           MAX_W   = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]           MIN_W   = {1'b1, {(W - 1){1'b0}}};
    localparam logic signed [W:0]      SL      = (W + 1)'(SLEW);
    localparam logic signed [W:0]      NEG_SL  = -SL;

    logic signed [SH_W-1:0] t_ext;
    logic signed [SH_W-1:0] shaped;
    logic [W-1:0]           target_p2_d, target_p2_q;
    logic                   over_p2_d, over_p2_q;
    logic signed [W:0]      diff;
    logic signed [W:0]      step;
    logic [W-1:0]           spd_d, spd_q;

    function automatic logic [W-1:0] sat_w(input logic signed [SH_W-1:0] v);
        if (v > SAT_MAX) return MAX_W;
        if (v < SAT_MIN) return MIN_W;
        return v[W-1:0];
    endfunction

    // Stage 2: deadzone offset outside the low-torque band, gain inside it.
    always_comb begin
        t_ext  = {{2{torque[W]}}, torque};
        shaped = '0;
        if (pwr_p1) begin
            if (t_ext > LB)
                shaped = t_ext + MD;
            else if (t_ext < NEG_LB)
                shaped = t_ext - MD;
            else
                shaped = t_ext <<< GAIN_SHIFT;
        end
        target_p2_d = sat_w(shaped);
        over_p2_d   = (shaped > OV);
    end

    // Stage 3: step toward the target by at most SLEW; power loss drops to 0 at once.
    always_comb begin
        diff = {target_p2_q[W-1], target_p2_q} - {spd_q[W-1], spd_q};
        step = diff;
        if (diff > SL)
            step = SL;
        else if (diff < NEG_SL)
            step = NEG_SL;
        spd_d = spd_q;
        if (vld_p2) begin
            if (!pwr_p2)
                spd_d = '0;
            else if (SLEW == 0)
                spd_d = target_p2_q;
            else
                spd_d = W'({spd_q[W-1], spd_q} + step);
        end
    end

    // Pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_p2_q <= '0;
            over_p2_q   <= 1'b0;
            spd_q       <= '0;
        end else begin
            target_p2_q <= target_p2_d;
            over_p2_q   <= over_p2_d;
            spd_q       <= spd_d;
        end
    end

    assign spd     = spd_q;
    assign over_p2 = over_p2_q;

endmodule

// File: rtl/segway_math_pipe.sv
// Segway wheel-speed math: soft-start scaling and steering (stage 1), per-wheel
// shaping (stage 2), slew-limited outputs and overspeed debounce (stage 3).
module segway_math_pipe
    import segway_pkg::*;
#(
    parameter int W          = SEG_W,
    parameter int SS_W       = SEG_SS_W,
    parameter int SS_STEP    = SEG_SS_STEP,
    parameter int MIN_DUTY   = SEG_MIN_DUTY,
    parameter int LOW_BAND   = SEG_LOW_BAND,
    parameter int GAIN_SHIFT = SEG_GAIN_SHIFT,
    parameter int STEER_LO   = SEG_STEER_LO,
    parameter int STEER_HI   = SEG_STEER_HI,
    parameter int OVERSPEED  = SEG_OVERSPEED,
    parameter int FAST_CNT   = SEG_FAST_CNT,
    parameter int SLEW       = SEG_SLEW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [W-1:0] PID_cntrl,
    input  logic [W-1:0] steer_pot,
    input  logic         en_steer,
    input  logic         pwr_up,
    output logic         vld_out,
    output logic [W-1:0] lft_spd,
    output logic [W-1:0] rght_spd,
    output logic         too_fast,
    output logic         ss_done
);

    localparam logic [SS_W-1:0]  SS_MAX  = {SS_W{1'b1}};
    localparam logic [SS_W-1:0]  SS_INC  = SS_W'(SS_STEP);
    localparam logic [W-1:0]     ST_LO   = W'(STEER_LO);
    localparam logic [W-1:0]     ST_HI   = W'(STEER_HI);
    localparam logic [W-1:0]     ST_MID  = W'((2 ** (W - 1)) - 1);
    localparam int               CNT_W   = $clog2(FAST_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAST_CNT);

    logic [SS_W-1:0]         ss_tmr_d, ss_tmr_q;
    logic signed [W+SS_W:0]  pid_ext, ss_ext, pid_prod;
    logic signed [W-1:0]     steer_s;
    logic [W-1:0]            pid_ss_p1_d, pid_ss_p1_q;
    logic [W-1:0]            st_p1_d, st_p1_q;
    logic                    vld_p1_d, vld_p1_q, pwr_p1_d, pwr_p1_q;
    logic                    vld_p2_d, vld_p2_q, pwr_p2_d, pwr_p2_q;
    logic                    vld_out_d, vld_out_q;
    logic [W:0]              torque_l, torque_r;
    logic                    over_l, over_r;
    logic [CNT_W-1:0]        fast_cnt_d, fast_cnt_q;
    logic                    too_fast_d, too_fast_q;

    function automatic logic [W-1:0] clamp_steer(input logic [W-1:0] p);
        if (p < ST_LO) return ST_LO;
        if (p > ST_HI) return ST_HI;
        return p;
    endfunction

    // Soft-start timer: advances per accepted sample, cleared while powered down.
    always_comb begin
        ss_tmr_d = ss_tmr_q;
        if (vld_in) begin
            if (!pwr_up)
                ss_tmr_d = '0;
            else if (ss_tmr_q > SS_MAX - SS_INC)
                ss_tmr_d = SS_MAX;
            else
                ss_tmr_d = ss_tmr_q + SS_INC;
        end
    end

    // Stage 1: scale PID by the pre-update timer (bypassed at full scale) and form steering.
    always_comb begin
        pid_ext     = {{(SS_W + 1){PID_cntrl[W-1]}}, PID_cntrl};
        ss_ext      = {{(W + 1){1'b0}}, ss_tmr_q};
        pid_prod    = pid_ext * ss_ext;
        pid_ss_p1_d = (ss_tmr_q == SS_MAX) ? PID_cntrl : W'(pid_prod >>> SS_W);
        steer_s     = $signed(clamp_steer(steer_pot) - ST_MID);
        st_p1_d     = en_steer ? W'((steer_s >>> 4) + (steer_s >>> 3)) : '0;
        vld_p1_d    = vld_in;
        pwr_p1_d    = pwr_up;
    end

    // Stage 2: differential torque for each wheel.
    always_comb begin
        torque_l = {pid_ss_p1_q[W-1], pid_ss_p1_q} + {st_p1_q[W-1], st_p1_q};
        torque_r = {pid_ss_p1_q[W-1], pid_ss_p1_q} - {st_p1_q[W-1], st_p1_q};
        vld_p2_d = vld_p1_q;
        pwr_p2_d = pwr_p1_q;
    end

    // Stage 3: debounce overspeed over consecutive valid samples.
    always_comb begin
        vld_out_d  = vld_p2_q;
        fast_cnt_d = fast_cnt_q;
        too_fast_d = too_fast_q;
        if (vld_p2_q) begin
            if (over_l || over_r)
                fast_cnt_d = (fast_cnt_q == CNT_MAX) ? CNT_MAX : fast_cnt_q + CNT_W'(1);
            else
                fast_cnt_d = '0;
            too_fast_d = (fast_cnt_d == CNT_MAX);
        end
    end

    // Control and stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_tmr_q    <= '0;
            pid_ss_p1_q <= '0;
            st_p1_q     <= '0;
            vld_p1_q    <= 1'b0;
            pwr_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            pwr_p2_q    <= 1'b0;
            vld_out_q   <= 1'b0;
            fast_cnt_q  <= '0;
            too_fast_q  <= 1'b0;
        end else begin
            ss_tmr_q    <= ss_tmr_d;
            pid_ss_p1_q <= pid_ss_p1_d;
            st_p1_q     <= st_p1_d;
            vld_p1_q    <= vld_p1_d;
            pwr_p1_q    <= pwr_p1_d;
            vld_p2_q    <= vld_p2_d;
            pwr_p2_q    <= pwr_p2_d;
            vld_out_q   <= vld_out_d;
            fast_cnt_q  <= fast_cnt_d;
            too_fast_q  <= too_fast_d;
        end
    end

    wheel_shaper #(
        .W(W), .MIN_DUTY(MIN_DUTY), .LOW_BAND(LOW_BAND), .GAIN_SHIFT(GAIN_SHIFT),
        .OVERSPEED(OVERSPEED), .SLEW(SLEW)
    ) u_shaper_l (
        .clk(clk), .rst(rst), .vld_p1(vld_p1_q), .pwr_p1(pwr_p1_q), .torque(torque_l),
        .vld_p2(vld_p2_q), .pwr_p2(pwr_p2_q), .spd(lft_spd), .over_p2(over_l)
    );

    wheel_shaper #(
        .W(W), .MIN_DUTY(MIN_DUTY), .LOW_BAND(LOW_BAND), .GAIN_SHIFT(GAIN_SHIFT),
        .OVERSPEED(OVERSPEED), .SLEW(SLEW)
    ) u_shaper_r (
        .clk(clk), .rst(rst), .vld_p1(vld_p1_q), .pwr_p1(pwr_p1_q), .torque(torque_r),
        .vld_p2(vld_p2_q), .pwr_p2(pwr_p2_q), .spd(rght_spd), .over_p2(over_r)
    );

    assign vld_out  = vld_out_q;
    assign too_fast = too_fast_q;
    assign ss_done  = (ss_tmr_q == SS_MAX);

endmodule
